mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an operation.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port A  input  WIDTH  first operand / dividend.
REQ-007 SHALL have port B  input  WIDTH  second operand / divisor.
REQ-008 SHALL have port hi_we  input  1  direct write of HI (MTHI).
REQ-009 SHALL have port lo_we  input  1  direct write of LO (MTLO).
REQ-010 SHALL have port wdata  input  WIDTH  data for hi_we/lo_we.
REQ-011 SHALL have port busy  output  1  high while an operation is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-013 SHALL have port hi  output  WIDTH  registered HI (product upper half / remainder).
REQ-014 SHALL have port lo  output  WIDTH  registered LO (product lower half / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FIX; busy = (state != IDLE).
REQ-016 SHALL, in IDLE with start=1, latch op, A and B and enter RUN at that edge (edge S), with iteration counter cleared.
REQ-017 SHALL ignore start, hi_we and lo_we while busy.
REQ-018 SHALL, for signed ops, operate on magnitudes |A|, |B|, and record the result signs: product sign A^B; quotient sign A^B; remainder sign = sign of A.
REQ-019 SHALL, in RUN, perform exactly one iteration per cycle for WIDTH cycles: a shift-add multiply step into a 2*WIDTH accumulator, or a restoring divide step (shift, trial-subtract, set quotient bit).
REQ-020 SHALL go from RUN to FIX after the WIDTH-th iteration, and from FIX to IDLE on the next edge (edge S+WIDTH+1).
REQ-021 SHALL, at the FIX->IDLE edge, apply two's-complement sign correction and write {hi,lo}; done is high for exactly the following cycle.
REQ-022 SHALL give MULT/MULTU {hi,lo} = the full 2*WIDTH-bit signed/unsigned product.
REQ-023 SHALL give DIV/DIVU lo = quotient truncated toward zero and hi = remainder.
REQ-024 SHALL, on divide by zero (B=0), give lo = all ones and hi = A, for both DIV and DIVU.
REQ-025 SHALL, on signed overflow (DIV with A = most negative value, B = -1), give lo = A and hi = 0.
REQ-026 SHALL accept a new start in the cycle where done=1 (state is IDLE).
REQ-027 SHALL, in IDLE, write wdata to hi when hi_we=1 and/or to lo when lo_we=1, at the edge; both may be written in the same cycle.
REQ-028 SHALL, when start and hi_we/lo_we are asserted in the same IDLE cycle, perform the direct write and also start the operation; the operation result later overwrites both registers.
REQ-029 SHALL hold hi/lo stable at all times other than a REQ-021 or REQ-027 write.

Reset
REQ-030 SHALL, while reset=1, immediately force state=IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, regardless of clock.
REQ-031 SHALL, when reset is asserted mid-operation, abandon that operation with no HI/LO update and no done pulse after release.
REQ-032 SHALL accept start on the first rising edge after reset deasserts.

Verification (WIDTH=32)
REQ-033 SHALL pass: MULT, A=0xFFFFFFFE (-2), B=3 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy high for 32+1 cycles.
REQ-034 SHALL pass: MULTU, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 SHALL pass: DIV, A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU, A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-036 SHALL pass: DIV, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 SHALL pass: start pulses and hi_we=1 (wdata=0x1234) applied while busy -> all ignored, and the final result is unaffected; a start issued in the done cycle launches the next operation, with busy back high on the next cycle.
REQ-038 SHALL pass: reset asserted at iteration 10 -> busy=0, hi=lo=0 immediately, with no done pulse; after release, hi_we with wdata=0x55 -> hi=0x55 on the next edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring-divide step per cycle,
// followed by a sign-correction cycle that writes the result into HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               isDiv_q, isDiv_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   aOrig_q, aOrig_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               aNeg, bNeg;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quot, rem;

  // Magnitudes of the operands; op[0]=1 selects the unsigned variants.
  always_comb begin
    aNeg = ~op[0] & A[WIDTH-1];
    bNeg = ~op[0] & B[WIDTH-1];
    absA = aNeg ? -A : A;
    absB = bNeg ? -B : B;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mulNext  = {mulSum, acc_q[WIDTH-1:1]};
    divTrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    divNext  = divTrial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                               : {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prodFix  = negRes_q ? -acc_q : acc_q;
    quot     = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    isDiv_d   = isDiv_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    divZero_d = divZero_q;
    opnd_d    = opnd_q;
    aOrig_d   = aOrig_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d   = RUN;
          cnt_d     = '0;
          isDiv_d   = op[1];
          negRes_d  = aNeg ^ bNeg;
          negRem_d  = aNeg;
          divZero_d = (B == '0);
          opnd_d    = absB;
          aOrig_d   = A;
          acc_d     = {{WIDTH{1'b0}}, absA};
        end
      end
      RUN: begin
        acc_d = isDiv_q ? divNext : mulNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        // Most-negative / -1 needs no special case: |A|/1 negated zero times gives A back.
        if (!isDiv_q) begin
          {hi_d, lo_d} = prodFix;
        end else if (divZero_q) begin
          lo_d = '1;
          hi_d = aOrig_q;
        end else begin
          lo_d = negRes_q ? -quot : quot;
          hi_d = negRem_q ? -rem : rem;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negRes_q  <= 1'b0;
      negRem_q  <= 1'b0;
      divZero_q <= 1'b0;
      opnd_q    <= '0;
      aOrig_q   <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      isDiv_q   <= isDiv_d;
      negRes_q  <= negRes_d;
      negRem_q  <= negRem_d;
      divZero_q <= divZero_d;
      opnd_q    <= opnd_d;
      aOrig_q   <= aOrig_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
